// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the framed UART transmit arbiter.
// Imported by the arbiter top level and its round-robin grant block.
package uart_tx_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StHdr,
      StLen,
      StFetch,
      StLat,
      StData,
      StCsum,
      StWait,
      StDone
   } state_e;

   localparam logic SRC_DDR = 1'b0;
   localparam logic SRC_RSP = 1'b1;

   localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

   function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic id);
      return base | {7'd0, id};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Contention goes to the source that did not win last time.
// The grant history only advances when a grant is actually taken (en high).
module rr_arb2
   import uart_tx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt,
   output logic gnt_id
);

   logic last_q;

   always_comb begin
      gnt = en & (req0 | req1);
      if (req0 && req1) begin
         gnt_id = ~last_q;
      end else begin
         gnt_id = req1 ? SRC_RSP : SRC_DDR;
      end
   end

   // Reset to src1 so src0 wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= SRC_RSP;
      end else if (gnt) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between two byte FIFOs, sending whole frames
// (header, length, payload, XOR checksum) granted round-robin.
module uart_tx_arbiter
   import uart_tx_pkg::*;
#(
   parameter logic [7:0]  HDR_BASE         = HDR_BASE_DEFAULT,
   parameter int unsigned UNDERRUN_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s0_req,
   input  logic [7:0] s0_len,
   input  logic       s0_empty,
   input  logic [7:0] s0_data,
   output logic       s0_rd_en,
   output logic       s0_ack,
   input  logic       s1_req,
   input  logic [7:0] s1_len,
   input  logic       s1_empty,
   input  logic [7:0] s1_data,
   output logic       s1_rd_en,
   output logic       s1_ack,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_done,
   output logic       busy,
   output logic       frame_done,
   output logic       err_underrun,
   input  logic       err_clr
);

   localparam int unsigned TmoW    = (UNDERRUN_TIMEOUT > 1) ? $clog2(UNDERRUN_TIMEOUT) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(UNDERRUN_TIMEOUT - 1);
   localparam bit          TmoEn   = (UNDERRUN_TIMEOUT != 0);

   state_e          state_q, state_d;
   state_e          ret_q, ret_d;
   logic            sel_q, sel_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      csum_q, csum_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            rd_en_q, rd_en_d;
   logic [1:0]      ack_q, ack_d;
   logic            frame_done_q, frame_done_d;
   logic            err_q, err_d;
   logic            pad_q, pad_d;
   logic [TmoW-1:0] tmo_q, tmo_d;

   logic       arb_en, gnt, gnt_id;
   logic       sel_empty, underrun;
   logic [7:0] sel_data, data_byte, hdr;

   assign arb_en = (state_q == StIdle);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (arb_en),
      .req0   (s0_req),
      .req1   (s1_req),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign sel_empty = sel_q ? s1_empty : s0_empty;
   assign sel_data  = sel_q ? s1_data : s0_data;
   assign hdr       = hdr_byte(HDR_BASE, sel_q);
   assign data_byte = pad_q ? 8'h00 : sel_data;

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      sel_d        = sel_q;
      len_d        = len_q;
      csum_d       = csum_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = 1'b0;
      rd_en_d      = 1'b0;
      ack_d        = 2'b00;
      frame_done_d = 1'b0;
      pad_d        = pad_q;
      tmo_d        = tmo_q;
      underrun     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (gnt) begin
               sel_d   = gnt_id;
               len_d   = gnt_id ? s1_len : s0_len;
               ack_d   = gnt_id ? 2'b10 : 2'b01;
               state_d = StHdr;
            end
         end
         StHdr: begin
            tx_data_d  = hdr;
            tx_valid_d = 1'b1;
            csum_d     = hdr;
            ret_d      = StLen;
            state_d    = StWait;
         end
         StLen: begin
            tx_data_d  = len_q;
            tx_valid_d = 1'b1;
            csum_d     = csum_q ^ len_q;
            ret_d      = (len_q == 8'd0) ? StCsum : StFetch;
            state_d    = StWait;
         end
         StFetch: begin
            if (!sel_empty) begin
               rd_en_d = 1'b1;
               tmo_d   = '0;
               pad_d   = 1'b0;
               state_d = StLat;
            end else if (TmoEn) begin
               // Give up waiting on a starved FIFO and send a zero pad byte instead.
               if (tmo_q == TmoLast) begin
                  tmo_d    = '0;
                  pad_d    = 1'b1;
                  underrun = 1'b1;
                  state_d  = StData;
               end else begin
                  tmo_d = tmo_q + TmoW'(1);
               end
            end
         end
         StLat: begin
            state_d = StData;
         end
         StData: begin
            tx_data_d  = data_byte;
            tx_valid_d = 1'b1;
            csum_d     = csum_q ^ data_byte;
            len_d      = len_q - 8'd1;
            ret_d      = (len_q == 8'd1) ? StCsum : StFetch;
            pad_d      = 1'b0;
            state_d    = StWait;
         end
         StCsum: begin
            tx_data_d  = csum_q;
            tx_valid_d = 1'b1;
            ret_d      = StDone;
            state_d    = StWait;
         end
         StWait: begin
            if (tx_done) begin
               state_d = ret_q;
            end
         end
         StDone: begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A fresh underrun outranks a clear in the same cycle.
      err_d = underrun | (err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ret_q        <= StIdle;
         sel_q        <= SRC_DDR;
         len_q        <= '0;
         csum_q       <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         rd_en_q      <= 1'b0;
         ack_q        <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         pad_q        <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         sel_q        <= sel_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         rd_en_q      <= rd_en_d;
         ack_q        <= ack_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         pad_q        <= pad_d;
         tmo_q        <= tmo_d;
      end
   end

   assign s0_rd_en     = rd_en_q & ~sel_q;
   assign s1_rd_en     = rd_en_q & sel_q;
   assign s0_ack       = ack_q[0];
   assign s1_ack       = ack_q[1];
   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign busy         = (state_q != StIdle);
   assign frame_done   = frame_done_q;
   assign err_underrun = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised self-checking bench: FIFO and UART models plus a frame-level reference
// that predicts grant order and byte streams from the framing rules.
module tb_uart_tx_arbiter;

   localparam int unsigned TMO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       s0_req, s0_empty, s0_rd_en, s0_ack;
   logic [7:0] s0_len, s0_data;
   logic       s1_req, s1_empty, s1_rd_en, s1_ack;
   logic [7:0] s1_len, s1_data;
   logic [7:0] tx_data;
   logic       tx_valid, tx_done, busy, frame_done, err_underrun, err_clr;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .HDR_BASE         (8'hA0),
      .UNDERRUN_TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s0_req       (s0_req),
      .s0_len       (s0_len),
      .s0_empty     (s0_empty),
      .s0_data      (s0_data),
      .s0_rd_en     (s0_rd_en),
      .s0_ack       (s0_ack),
      .s1_req       (s1_req),
      .s1_len       (s1_len),
      .s1_empty     (s1_empty),
      .s1_data      (s1_data),
      .s1_rd_en     (s1_rd_en),
      .s1_ack       (s1_ack),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_done      (tx_done),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_underrun (err_underrun),
      .err_clr      (err_clr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // FIFO contents as seen by the DUT, and the reference copies the model consumes.
   logic [7:0] fifo0[$], fifo1[$], m0[$], m1[$];
   logic [7:0] rx_q[$], exp_q[$];
   int         tv_t[$], td_t[$];
   int         cyc = 0;
   int         rd0_cnt = 0, rd1_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, fd_cnt = 0;
   int         uart_delay = 10;
   bit         uart_rand = 0, spur_en = 0;
   int         m_last = 1;

   bit         uart_busy = 0, hold_chk = 0, pend0 = 0, pend1 = 0;
   int         uart_cnt = 0;
   logic [7:0] held = 0, hold0 = 0, hold1 = 0;

   // FIFO and UART behaviour, evaluated once per cycle on the falling edge.
   initial begin
      s0_data = 8'h00; s1_data = 8'h00; s0_empty = 1'b1; s1_empty = 1'b1; tx_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         s0_data = pend0 ? hold0 : 8'($urandom);
         s1_data = pend1 ? hold1 : 8'($urandom);
         pend0 = 0;
         pend1 = 0;
         if (s0_rd_en || s1_rd_en) check("rd_excl", 32'(s0_rd_en & s1_rd_en), 32'd0);
         if (s0_rd_en) begin
            check("rd0_nonempty", 32'(fifo0.size() != 0), 32'd1);
            rd0_cnt++;
            if (fifo0.size() != 0) hold0 = fifo0.pop_front();
            pend0 = 1;
         end
         if (s1_rd_en) begin
            check("rd1_nonempty", 32'(fifo1.size() != 0), 32'd1);
            rd1_cnt++;
            if (fifo1.size() != 0) hold1 = fifo1.pop_front();
            pend1 = 1;
         end
         s0_empty = (fifo0.size() == 0);
         s1_empty = (fifo1.size() == 0);

         tx_done = 1'b0;
         if (rst) hold_chk = 0;
         if (uart_busy) begin
            if (hold_chk) check("tx_hold", 32'(tx_data), 32'(held));
            uart_cnt--;
            if (uart_cnt <= 0) begin
               tx_done   = 1'b1;
               uart_busy = 0;
               td_t.push_back(cyc);
            end
         end
         if (tx_valid) begin
            check("tx_no_overlap", 32'(uart_busy | tx_done), 32'd0);
            rx_q.push_back(tx_data);
            tv_t.push_back(cyc);
            held      = tx_data;
            hold_chk  = 1;
            uart_busy = 1;
            uart_cnt  = uart_rand ? int'($urandom_range(1, 6)) : uart_delay;
         end else if (!uart_busy && !tx_done && spur_en && $urandom_range(0, 7) == 0) begin
            tx_done = 1'b1;
         end
         if (s0_ack) ack0_cnt++;
         if (s1_ack) ack1_cnt++;
         if (frame_done) fd_cnt++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_obs();
      rx_q.delete(); exp_q.delete(); tv_t.delete(); td_t.delete();
      rd0_cnt = 0; rd1_cnt = 0; ack0_cnt = 0; ack1_cnt = 0; fd_cnt = 0;
   endtask

   task automatic push_byte(input int src, input logic [7:0] b);
      if (src == 0) begin fifo0.push_back(b); m0.push_back(b); end
      else begin fifo1.push_back(b); m1.push_back(b); end
   endtask

   task automatic expect_frame(input int src, input int len);
      logic [7:0] b, cs;
      cs = 8'hA0 | 8'(src);
      exp_q.push_back(cs);
      exp_q.push_back(8'(len));
      cs = cs ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         b = (src == 0) ? m0.pop_front() : m1.pop_front();
         exp_q.push_back(b);
         cs = cs ^ b;
      end
      exp_q.push_back(cs);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_fd(input int target, input int budget, input string tag);
      int n = 0;
      while (fd_cnt < target && n < budget) begin tick(); n++; end
      if (fd_cnt < target) check({tag, "_frame_timeout"}, 32'(fd_cnt), 32'(target));
   endtask

   task automatic wait_rx(input int target, input int budget, input string tag);
      int n = 0;
      while (rx_q.size() < target && n < budget) begin tick(); n++; end
      if (rx_q.size() < target) check({tag, "_byte_timeout"}, 32'(rx_q.size()), 32'(target));
   endtask

   // Raise the given requests, drop each on its ack (scrambling its length), wait for frames.
   task automatic run_frames(input bit r0, input bit r1, input int budget, input string tag);
      int n = 0;
      bit need0 = r0, need1 = r1;
      int target = fd_cnt + int'(r0) + int'(r1);
      s0_req = r0;
      s1_req = r1;
      while ((need0 || need1) && n < budget) begin
         tick();
         n++;
         if (s0_ack) begin need0 = 0; s0_req = 1'b0; s0_len = 8'($urandom); end
         if (s1_ack) begin need1 = 0; s1_req = 1'b0; s1_len = 8'($urandom); end
      end
      s0_req = 1'b0;
      s1_req = 1'b0;
      if (need0 || need1) check({tag, "_grant_timeout"}, 32'(need0 | need1), 32'd0);
      wait_fd(target, budget, tag);
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({tx_valid, tx_data, busy, frame_done, err_underrun,
                  s0_rd_en, s0_ack, s1_rd_en, s1_ack});
   endfunction

   initial begin
      int sz, rdsv;
      logic [7:0] b1, b3;
      rst = 1'b1; s0_req = 1'b0; s1_req = 1'b0; s0_len = 8'd0; s1_len = 8'd0; err_clr = 1'b0;
      repeat (3) tick();
      check("reset_outputs_in_rst", out_vec(), 32'd0);
      rst = 1'b0;
      tick();
      check("reset_outputs", out_vec(), 32'd0);

      // Directed: src0 len 2 with fixed UART latency, including grant and header latency.
      clear_obs();
      push_byte(0, 8'h11);
      push_byte(0, 8'h22);
      m0.delete();
      repeat (2) tick();
      s0_len = 8'd2;
      s0_req = 1'b1;
      tick();
      check("ack_latency", 32'(s0_ack), 32'd1);
      s0_req = 1'b0;
      tick();
      check("hdr_latency", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA0}));
      wait_fd(1, 500, "single");
      exp_q = '{8'hA0, 8'h02, 8'h11, 8'h22, 8'h91};
      if (tv_t.size() > 2 && td_t.size() > 1) check("payload_gap", 32'(tv_t[2] - td_t[1]), 32'd4);
      else check("payload_gap_missing", 32'(tv_t.size()), 32'd3);
      compare_stream("single");
      check("single_rd0", 32'(rd0_cnt), 32'd2);
      check("single_rd1", 32'(rd1_cnt), 32'd0);
      check("single_ack0", 32'(ack0_cnt), 32'd1);
      check("single_idle", 32'(busy), 32'd0);
      m_last = 0;

      // Both held high: grants alternate, starting from the source other than last.
      clear_obs();
      for (int k = 0; k < 2; k++) begin
         push_byte(0, 8'($urandom));
         push_byte(1, 8'($urandom));
      end
      repeat (2) tick();
      s0_len = 8'd1; s1_len = 8'd1; s0_req = 1'b1; s1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_frame((m_last == 1) ? 0 : 1, 1);
         m_last = (m_last == 1) ? 0 : 1;
      end
      begin
         int n = 0;
         while (ack0_cnt + ack1_cnt < 4 && n < 2000) begin tick(); n++; end
      end
      s0_req = 1'b0; s1_req = 1'b0;
      wait_fd(4, 2000, "alt");
      compare_stream("alt");
      check("alt_acks", 32'({ack0_cnt[3:0], ack1_cnt[3:0]}), 32'h22);

      // src1 empty frame.
      clear_obs();
      s1_len = 8'd0;
      expect_frame(1, 0);
      m_last = 1;
      run_frames(1'b0, 1'b1, 500, "len0");
      compare_stream("len0");
      check("len0_rd1", 32'(rd1_cnt), 32'd0);

      // Underrun: only the first byte is available until the pad has gone out.
      clear_obs();
      b1 = 8'($urandom);
      b3 = 8'($urandom);
      fifo0.push_back(b1);
      repeat (2) tick();
      s0_len = 8'd3;
      s0_req = 1'b1;
      begin
         int n = 0;
         while (!s0_ack && n < 50) begin tick(); n++; end
      end
      s0_req = 1'b0;
      wait_rx(4, 500, "underrun");
      fifo0.push_back(b3);
      wait_fd(1, 500, "underrun");
      m0 = '{b1, 8'h00, b3};
      expect_frame(0, 3);
      m_last = 0;
      if (tv_t.size() > 3 && td_t.size() > 2)
         check("pad_gap", 32'(tv_t[3] - td_t[2]), 32'(TMO + 2));
      else check("pad_gap_missing", 32'(tv_t.size()), 32'd4);
      compare_stream("underrun");
      check("underrun_rd0", 32'(rd0_cnt), 32'd2);
      check("err_set", 32'(err_underrun), 32'd1);
      tick();
      check("err_sticky", 32'(err_underrun), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_cleared", 32'(err_underrun), 32'd0);

      // Reset in mid-frame, then check the arbiter history was reset as well.
      clear_obs();
      for (int k = 0; k < 4; k++) push_byte(0, 8'($urandom));
      repeat (2) tick();
      s0_len = 8'd4;
      s0_req = 1'b1;
      begin
         int n = 0;
         while (!s0_ack && n < 50) begin tick(); n++; end
      end
      s0_req = 1'b0;
      wait_rx(4, 500, "abort");
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_outputs", out_vec(), 32'd0);
      sz = rx_q.size();
      rdsv = rd0_cnt;
      repeat (20) tick();
      check("abort_no_tx", 32'(rx_q.size()), 32'(sz));
      check("abort_no_rd", 32'(rd0_cnt), 32'(rdsv));
      check("abort_idle", 32'(busy), 32'd0);
      fifo0.delete(); m0.delete();
      clear_obs();
      m_last = 1;
      push_byte(0, 8'($urandom));
      push_byte(1, 8'($urandom));
      repeat (2) tick();
      s0_len = 8'd1; s1_len = 8'd1;
      expect_frame(0, 1);
      expect_frame(1, 1);
      m_last = 1;
      run_frames(1'b1, 1'b1, 1000, "post_rst");
      compare_stream("post_rst");

      // Randomised frames with random UART latency and spurious tx_done pulses.
      spur_en = 1;
      uart_rand = 1;
      for (int it = 0; it < 12; it++) begin
         int unsigned pick;
         bit r0, r1;
         int l0, l1;
         clear_obs();
         pick = $urandom_range(1, 3);
         r0 = pick[0];
         r1 = pick[1];
         l0 = $urandom_range(0, 5);
         l1 = $urandom_range(0, 5);
         if (it == 3) begin r0 = 1; l0 = 255; end
         if (r0) begin
            s0_len = 8'(l0);
            for (int k = 0; k < l0; k++) push_byte(0, 8'($urandom));
         end
         if (r1) begin
            s1_len = 8'(l1);
            for (int k = 0; k < l1; k++) push_byte(1, 8'($urandom));
         end
         repeat (2) tick();
         if (r0 && r1) begin
            if (m_last == 1) begin
               expect_frame(0, l0); expect_frame(1, l1); m_last = 1;
            end else begin
               expect_frame(1, l1); expect_frame(0, l0); m_last = 0;
            end
         end else if (r0) begin
            expect_frame(0, l0); m_last = 0;
         end else begin
            expect_frame(1, l1); m_last = 1;
         end
         run_frames(r0, r1, 6000, $sformatf("rand%0d", it));
         compare_stream($sformatf("rand%0d", it));
         check($sformatf("rand%0d_rd0", it), 32'(rd0_cnt), 32'(r0 ? l0 : 0));
         check($sformatf("rand%0d_rd1", it), 32'(rd1_cnt), 32'(r1 ? l1 : 0));
         repeat ($urandom_range(1, 12)) tick();
         check($sformatf("rand%0d_idle", it), 32'(busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
